// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller
// Multi-floor elevator controller. Floor calls are latched into a pending
// bitmap and served in SCAN order: the car keeps its travel direction while
// calls remain ahead of it, then reverses. At each served floor the door is
// held open for a programmable dwell. A single 32-bit tick counter times both
// travel between floors and the door dwell.
module elevator_scan_controller #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int TRAVEL_TICKS = 10000000,
  parameter int DOOR_TICKS   = 20000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  output logic                  call_accept,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  idle
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_t;

  localparam logic [31:0] TRAVEL_LAST = 32'(TRAVEL_TICKS - 1);
  localparam logic [31:0] DOOR_LAST   = 32'(DOOR_TICKS - 1);

  state_t                  state_r, state_s;
  logic [31:0]             cnt_r, cnt_s;
  logic [FLOOR_W-1:0]      floor_r, floor_s;
  logic                    dir_up_r, dir_up_s;
  logic [NUM_FLOORS-1:0]   pending_r, pending_s;

  logic [FLOOR_W-1:0]      floor_up_s;
  logic [FLOOR_W-1:0]      floor_dn_s;
  logic                    absorb_s;
  logic                    call_here_s;
  logic                    call_up_s;
  logic                    call_dn_s;
  logic [NUM_FLOORS-1:0]   set_mask_s;
  logic [NUM_FLOORS-1:0]   req_s;
  logic [NUM_FLOORS-1:0]   clr_mask_s;
  logic                    clr_en_s;
  logic [FLOOR_W-1:0]      clr_floor_s;
  logic                    above_s;
  logic                    below_s;
  logic                    here_pend_s;
  logic                    up_hit_s;
  logic                    dn_hit_s;
  logic                    beyond_up_s;
  logic                    beyond_dn_s;

  // Only in-range floors are accepted; this path is purely combinational.
  assign call_accept = call_valid && (32'(call_floor) < 32'(NUM_FLOORS));

  assign floor_up_s  = floor_r + FLOOR_W'(1);
  assign floor_dn_s  = floor_r - FLOOR_W'(1);
  assign call_here_s = call_accept && (call_floor == floor_r);
  assign call_up_s   = call_accept && (call_floor == floor_up_s);
  assign call_dn_s   = call_accept && (call_floor == floor_dn_s);

  // A call to the floor where the car already stands (door open or idle)
  // is served on the spot and never enters the bitmap.
  assign absorb_s = call_here_s && ((state_r == S_IDLE) || (state_r == S_DOOR_OPEN));

  // Decode the incoming call into a one-hot set mask.
  always_comb begin
    set_mask_s = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_mask_s[i] = call_accept && !absorb_s && (call_floor == FLOOR_W'(i));
    end
  end

  assign req_s = pending_r | set_mask_s;

  // Scan the bitmap for calls relative to the car and to the next floor.
  always_comb begin
    above_s     = 1'b0;
    below_s     = 1'b0;
    here_pend_s = 1'b0;
    up_hit_s    = 1'b0;
    dn_hit_s    = 1'b0;
    beyond_up_s = 1'b0;
    beyond_dn_s = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_s     = above_s     | (pending_r[i] && (FLOOR_W'(i) > floor_r));
      below_s     = below_s     | (pending_r[i] && (FLOOR_W'(i) < floor_r));
      here_pend_s = here_pend_s | (pending_r[i] && (FLOOR_W'(i) == floor_r));
      up_hit_s    = up_hit_s    | (pending_r[i] && (FLOOR_W'(i) == floor_up_s));
      dn_hit_s    = dn_hit_s    | (pending_r[i] && (FLOOR_W'(i) == floor_dn_s));
      beyond_up_s = beyond_up_s | (req_s[i] && (FLOOR_W'(i) > floor_up_s));
      beyond_dn_s = beyond_dn_s | (req_s[i] && (FLOOR_W'(i) < floor_dn_s));
    end
  end

  // Next-state, timing and floor-step decisions for the SCAN controller.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    floor_s     = floor_r;
    dir_up_s    = dir_up_r;
    clr_en_s    = 1'b0;
    clr_floor_s = floor_r;
    case (state_r)
      S_IDLE: begin
        if (here_pend_s || call_here_s) begin
          state_s  = S_DOOR_OPEN;
          clr_en_s = 1'b1;
          cnt_s    = 32'd0;
        end else if (above_s && (dir_up_r || !below_s)) begin
          state_s  = S_MOVE_UP;
          dir_up_s = 1'b1;
          cnt_s    = 32'd0;
        end else if (below_s) begin
          state_s  = S_MOVE_DOWN;
          dir_up_s = 1'b0;
          cnt_s    = 32'd0;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_MOVE_UP: begin
        if (cnt_r == TRAVEL_LAST) begin
          floor_s = floor_up_s;
          cnt_s   = 32'd0;
          if (up_hit_s || call_up_s) begin
            state_s     = S_DOOR_OPEN;
            clr_en_s    = 1'b1;
            clr_floor_s = floor_up_s;
          end else if (beyond_up_s) begin
            state_s = S_MOVE_UP;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      S_MOVE_DOWN: begin
        if (cnt_r == TRAVEL_LAST) begin
          floor_s = floor_dn_s;
          cnt_s   = 32'd0;
          if (dn_hit_s || call_dn_s) begin
            state_s     = S_DOOR_OPEN;
            clr_en_s    = 1'b1;
            clr_floor_s = floor_dn_s;
          end else if (beyond_dn_s) begin
            state_s = S_MOVE_DOWN;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      S_DOOR_OPEN: begin
        if (call_here_s) begin
          cnt_s = 32'd0;
        end else if (cnt_r == DOOR_LAST) begin
          state_s = S_IDLE;
          cnt_s   = 32'd0;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 32'd0;
      end
    endcase
  end

  // Clear mask for the served floor; clearing wins over a same-cycle set.
  always_comb begin
    clr_mask_s = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr_mask_s[i] = clr_en_s && (clr_floor_s == FLOOR_W'(i));
    end
  end

  assign pending_s = req_s & ~clr_mask_s;

  // State, counter, floor, direction and bitmap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 32'd0;
      floor_r   <= '0;
      dir_up_r  <= 1'b1;
      pending_r <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      floor_r   <= floor_s;
      dir_up_r  <= dir_up_s;
      pending_r <= pending_s;
    end
  end

  assign pending       = pending_r;
  assign current_floor = floor_r;
  assign dir_up        = dir_up_r;
  assign moving        = (state_r == S_MOVE_UP) || (state_r == S_MOVE_DOWN);
  assign door_open     = (state_r == S_DOOR_OPEN);
  assign idle          = (state_r == S_IDLE);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb_elevator_scan_controller
// Directed bench: 8 floors, 4-cycle travel, 3-cycle door dwell.
module tb_elevator_scan_controller;

  localparam int NUM_FLOORS   = 8;
  localparam int FLOOR_W      = 4;
  localparam int TRAVEL_TICKS = 4;
  localparam int DOOR_TICKS   = 3;

  logic                  clk;
  logic                  rst;
  logic                  call_valid;
  logic [FLOOR_W-1:0]    call_floor;
  logic                  call_accept;
  logic [NUM_FLOORS-1:0] pending;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic                  idle;

  int n_cmp;
  int n_err;
  int door_cnt;

  elevator_scan_controller #(
    .NUM_FLOORS   (NUM_FLOORS),
    .FLOOR_W      (FLOOR_W),
    .TRAVEL_TICKS (TRAVEL_TICKS),
    .DOOR_TICKS   (DOOR_TICKS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .call_valid    (call_valid),
    .call_floor    (call_floor),
    .call_accept   (call_accept),
    .pending       (pending),
    .current_floor (current_floor),
    .moving        (moving),
    .dir_up        (dir_up),
    .door_open     (door_open),
    .idle          (idle)
  );

  // 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a call for exactly one edge.
  task automatic issue(input logic [FLOOR_W-1:0] f);
    call_valid = 1'b1;
    call_floor = f;
    tick(1);
    call_valid = 1'b0;
    call_floor = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    call_valid = 1'b0;
    call_floor = 4'd0;
    #1;
    check_val("rst_floor",   32'(current_floor), 32'd0);
    check_val("rst_pending", 32'(pending),       32'h00);
    check_val("rst_idle",    32'(idle),          32'd1);
    check_val("rst_moving",  32'(moving),        32'd0);
    check_val("rst_door",    32'(door_open),     32'd0);
    check_val("rst_dir",     32'(dir_up),        32'd1);
    tick(2);
    rst = 1'b0;

    // Basic move 0 -> 3
    issue(4'd3);
    check_val("b_pend",    32'(pending), 32'h08);
    check_val("b_idle",    32'(idle),    32'd1);
    tick(1);
    check_val("b_moving",  32'(moving),  32'd1);
    check_val("b_dir",     32'(dir_up),  32'd1);
    tick(3);
    check_val("b_f0_hold", 32'(current_floor), 32'd0);
    tick(1);
    check_val("b_f1",      32'(current_floor), 32'd1);
    tick(4);
    check_val("b_f2",      32'(current_floor), 32'd2);
    tick(4);
    check_val("b_f3",      32'(current_floor), 32'd3);
    check_val("b_door",    32'(door_open),     32'd1);
    check_val("b_clr",     32'(pending),       32'h00);
    tick(2);
    check_val("b_door3",   32'(door_open),     32'd1);
    tick(1);
    check_val("b_door_off",32'(door_open),     32'd0);
    check_val("b_idle_end",32'(idle),          32'd1);

    // SCAN order: call 5, then 2 while passing floor 1
    do_reset();
    issue(4'd5);
    check_val("s_pend5",  32'(pending), 32'h20);
    tick(5);
    check_val("s_f1",     32'(current_floor), 32'd1);
    issue(4'd2);
    check_val("s_pend25", 32'(pending), 32'h24);
    tick(3);
    check_val("s_f2",     32'(current_floor), 32'd2);
    check_val("s_door2",  32'(door_open),     32'd1);
    check_val("s_pend_a", 32'(pending),       32'h20);
    tick(3);
    check_val("s_idle2",  32'(idle),          32'd1);
    tick(1);
    check_val("s_mv",     32'(moving),        32'd1);
    check_val("s_dir",    32'(dir_up),        32'd1);
    tick(12);
    check_val("s_f5",     32'(current_floor), 32'd5);
    check_val("s_door5",  32'(door_open),     32'd1);
    check_val("s_pend_b", 32'(pending),       32'h00);
    tick(3);
    check_val("s_idle5",  32'(idle),          32'd1);

    // Direction priority at floor 4 heading up: calls 1 and 6
    do_reset();
    issue(4'd4);
    tick(17);
    check_val("d_f4",     32'(current_floor), 32'd4);
    check_val("d_door4",  32'(door_open),     32'd1);
    issue(4'd1);
    issue(4'd6);
    check_val("d_pend",   32'(pending),       32'h42);
    tick(1);
    check_val("d_idle",   32'(idle),          32'd1);
    check_val("d_dir_a",  32'(dir_up),        32'd1);
    tick(1);
    check_val("d_up",     32'(moving),        32'd1);
    check_val("d_dir_b",  32'(dir_up),        32'd1);
    tick(8);
    check_val("d_f6",     32'(current_floor), 32'd6);
    check_val("d_door6",  32'(door_open),     32'd1);
    check_val("d_pend6",  32'(pending),       32'h02);
    tick(4);
    check_val("d_down",   32'(moving),        32'd1);
    check_val("d_dir_c",  32'(dir_up),        32'd0);
    tick(20);
    check_val("d_f1",     32'(current_floor), 32'd1);
    check_val("d_door1",  32'(door_open),     32'd1);
    check_val("d_pend1",  32'(pending),       32'h00);
    tick(3);
    check_val("d_idle1",  32'(idle),          32'd1);

    // Same-floor call at floor 2 with a dwell restart
    issue(4'd2);
    tick(5);
    check_val("sf_f2",    32'(current_floor), 32'd2);
    tick(3);
    check_val("sf_idle",  32'(idle),          32'd1);
    issue(4'd2);
    check_val("sf_door",  32'(door_open),     32'd1);
    check_val("sf_pend",  32'(pending),       32'h00);
    door_cnt = 1;
    tick(1);
    if (door_open) door_cnt = door_cnt + 1;
    issue(4'd2);
    if (door_open) door_cnt = door_cnt + 1;
    check_val("sf_pend2", 32'(pending),       32'h00);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (door_open) door_cnt = door_cnt + 1;
    end
    check_val("sf_dwell", 32'(door_cnt),      32'd5);
    check_val("sf_idle2", 32'(idle),          32'd1);

    // Invalid calls and accept boundary
    call_valid = 1'b1;
    call_floor = 4'd7;
    #1;
    check_val("acc_7",    32'(call_accept),   32'd1);
    call_floor = 4'd8;
    #1;
    check_val("acc_8",    32'(call_accept),   32'd0);
    call_floor = 4'd9;
    #1;
    check_val("acc_9",    32'(call_accept),   32'd0);
    tick(1);
    call_valid = 1'b0;
    call_floor = 4'd0;
    check_val("inv_pend", 32'(pending),       32'h00);
    check_val("inv_idle", 32'(idle),          32'd1);

    // Reset mid-move from floor 2 toward 6
    issue(4'd6);
    tick(5);
    check_val("r_f3",     32'(current_floor), 32'd3);
    check_val("r_pend",   32'(pending),       32'h40);
    check_val("r_mv",     32'(moving),        32'd1);
    rst = 1'b1;
    #1;
    check_val("r_floor0", 32'(current_floor), 32'd0);
    check_val("r_pend0",  32'(pending),       32'h00);
    check_val("r_idle",   32'(idle),          32'd1);
    check_val("r_moving", 32'(moving),        32'd0);
    call_valid = 1'b1;
    call_floor = 4'd3;
    #1;
    check_val("r_accept", 32'(call_accept),   32'd1);
    call_valid = 1'b0;
    call_floor = 4'd0;
    tick(1);
    rst = 1'b0;
    tick(2);
    check_val("r_post_idle", 32'(idle),       32'd1);
    check_val("r_post_pend", 32'(pending),    32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
